// File: rtl/register_file_32x32.sv
// 32 x WIDTH register file with a one-hot write select, two combinational read
// ports, a hardwired-zero register 0 and an optional same-cycle write bypass.
module register_file_32x32 #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [31:0]      Wsel,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    // Register 0 has no storage; only entries 1..31 exist.
    logic [WIDTH-1:0] regs [1:31];
    logic             write_active;

    assign write_active = RegWrite && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite) begin
            for (int i = 1; i < 32; i++) begin
                if (Wsel[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Address 0 falls through every match and stays at zero, bypass included.
    always_comb begin
        ReadData1 = '0;
        for (int i = 1; i < 32; i++) begin
            if (ReadRegister1 == 5'(i)) begin
                if (BYPASS && write_active && Wsel[i]) begin
                    ReadData1 = WriteData;
                end else begin
                    ReadData1 = regs[i];
                end
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        for (int i = 1; i < 32; i++) begin
            if (ReadRegister2 == 5'(i)) begin
                if (BYPASS && write_active && Wsel[i]) begin
                    ReadData2 = WriteData;
                end else begin
                    ReadData2 = regs[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_32x32.sv
// Self-checking bench: drives a bypassing and a non-bypassing register file in
// parallel and compares both against an array model of the register contents.
module tb_register_file_32x32;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [31:0] Wsel;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] byp_rd1, byp_rd2, nob_rd1, nob_rd2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model [0:31];

    register_file_32x32 #(.WIDTH(32), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .Wsel(Wsel),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2), .ReadData1(byp_rd1), .ReadData2(byp_rd2)
    );

    register_file_32x32 #(.WIDTH(32), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .Wsel(Wsel),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2), .ReadData1(nob_rd1), .ReadData2(nob_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value straight from the register-file rules.
    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'h0;
        if (byp && RegWrite && !reset && Wsel[addr]) return WriteData;
        return model[addr];
    endfunction

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Compares all four read ports against the model for the current inputs.
    task automatic checkOutput(input string tag);
        #1;
        check_value({tag, " byp.rd1"}, byp_rd1, exp_read(ReadRegister1, 1'b1));
        check_value({tag, " byp.rd2"}, byp_rd2, exp_read(ReadRegister2, 1'b1));
        check_value({tag, " nob.rd1"}, nob_rd1, exp_read(ReadRegister1, 1'b0));
        check_value({tag, " nob.rd2"}, nob_rd2, exp_read(ReadRegister2, 1'b0));
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic [31:0] sel,
                                 input logic [31:0] data, input logic [4:0] a1,
                                 input logic [4:0] a2);
        reset         = rst;
        RegWrite      = we;
        Wsel          = sel;
        WriteData     = data;
        ReadRegister1 = a1;
        ReadRegister2 = a2;
    endtask

    // Advance one rising edge and apply its effect to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 1; i < 32; i++) model[i] = 32'h0;
        end else if (RegWrite) begin
            for (int i = 1; i < 32; i++) if (Wsel[i]) model[i] = WriteData;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        tick();

        // Reset state
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17);
        checkOutput("reset_state_a");
        check_value("reset_r17_const", byp_rd2, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd1);
        checkOutput("reset_state_b");

        // Reset clears a written register
        applyStimulus(1'b0, 1'b1, 32'h1 << 5, 32'hDEADBEEF, 5'd5, 5'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
        checkOutput("r5_written");
        check_value("r5_written_const", nob_rd1, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
        checkOutput("r5_cleared");
        check_value("r5_cleared_const", byp_rd1, 32'h0);

        // Basic write / read of R9, neighbours untouched
        applyStimulus(1'b0, 1'b1, 32'h00000200, 32'h12345678, 5'd8, 5'd10);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9);
        checkOutput("r9_read");
        check_value("r9_const", nob_rd2, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd8, 5'd10);
        checkOutput("r8_r10");

        // Register 0 ignores writes, also under bypass
        applyStimulus(1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFF, 5'd0, 5'd0);
        checkOutput("r0_during_write");
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        checkOutput("r0_after_write");

        // RegWrite=0 gates the write
        applyStimulus(1'b0, 1'b1, 32'h00000008, 32'h0BADF00D, 5'd3, 5'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h00000008, 32'h77777777, 5'd3, 5'd3);
        tick();
        checkOutput("r3_gated");
        check_value("r3_gated_const", nob_rd1, 32'h0BADF00D);

        // Bypass versus stored read
        applyStimulus(1'b0, 1'b1, 32'h00000010, 32'h11111111, 5'd4, 5'd4);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h00000010, 32'h22222222, 5'd4, 5'd9);
        checkOutput("bypass_before_edge");
        check_value("bypass_byp_const", byp_rd1, 32'h22222222);
        check_value("bypass_nob_const", nob_rd1, 32'h11111111);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd4, 5'd4);
        checkOutput("bypass_after_edge");
        check_value("bypass_nob_after", nob_rd1, 32'h22222222);

        // Reset wins over a simultaneous write and suppresses bypass
        applyStimulus(1'b0, 1'b1, 32'h80000000, 32'h5A5A5A5A, 5'd31, 5'd31);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h80000000, 32'hA5A5A5A5, 5'd31, 5'd31);
        checkOutput("reset_prio_before");
        check_value("reset_prio_no_bypass", byp_rd1, 32'h5A5A5A5A);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd31);
        checkOutput("reset_prio_after");
        check_value("reset_prio_r31", byp_rd2, 32'h0);

        // Sweep: one-hot write to every register, then read back in opposite order
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h1 << i, 32'(i) * 32'h01010101, 5'd0, 5'd0);
            tick();
        end
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'(a), 5'(31 - a));
            checkOutput($sformatf("sweep_%0d", a));
            check_value($sformatf("sweep_const_%0d", a), nob_rd1,
                        (a == 0) ? 32'h0 : 32'(a) * 32'h01010101);
        end

        // Randomized traffic: mostly one-hot selects, some empty/multi-hot, rare resets
        for (int n = 0; n < 300; n++) begin
            logic [31:0] sel;
            case ($urandom_range(0, 9))
                0:       sel = 32'h0;
                1:       sel = $urandom();
                default: sel = 32'h1 << $urandom_range(0, 31);
            endcase
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), sel,
                          $urandom(), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            checkOutput($sformatf("rand_%0d", n));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
